// File: rtl/jk_pkg.sv
// Shared constants for the JK excitation driver: FSM state encoding and
// the don't-care resolution policies.
package jk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_RESP  = 2'd3
    } jk_state_t;

    localparam int JK_POL_SETRESET = 0;
    localparam int JK_POL_TOGGLE   = 1;

endpackage

// File: rtl/jk_excite.sv
// Combinational JK excitation: per bit, the J/K pair that moves a JK cell
// from present state q to target t, with don't-cares resolved by USE_TOGGLE.
module jk_excite
    import jk_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int USE_TOGGLE = JK_POL_SETRESET
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] j_n,
    output logic [WIDTH-1:0] k_n
);

    localparam logic DC = (USE_TOGGLE == JK_POL_TOGGLE);

    // q=0: J decides the next state and K is free; q=1: K decides and J is free.
    always_comb begin
        j_n = '0;
        k_n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            j_n[i] = q[i] ? DC : t[i];
            k_n[i] = q[i] ? ~t[i] : DC;
        end
    end

endmodule

// File: rtl/jk_excite_driver.sv
// Drives a bank of JK cells to a requested word for one clock, then reads the
// bank back and reports match/mismatch with a saturating mismatch counter.
module jk_excite_driver
    import jk_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int USE_TOGGLE = JK_POL_SETRESET,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_match,
    output logic [WIDTH-1:0] rsp_q,
    output logic [ERR_W-1:0] err_cnt
);

    // Handshakes: a word moves on any posedge where valid and ready are both
    // high; the sender holds valid/data until then, the receiver may change
    // ready freely, and rsp_* stay stable while rsp_valid is high and unaccepted.

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    jk_state_t        state, state_n;
    logic [WIDTH-1:0] tgt_r;
    logic [WIDTH-1:0] j_n, k_n;

    jk_excite #(
        .WIDTH      (WIDTH),
        .USE_TOGGLE (USE_TOGGLE)
    ) u_excite (
        .q   (q_fb),
        .t   (tgt_data),
        .j_n (j_n),
        .k_n (k_n)
    );

    always_comb begin
        state_n   = state;
        tgt_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                tgt_ready = 1'b1;
                if (tgt_valid) state_n = ST_DRIVE;
            end
            ST_DRIVE: state_n = ST_CHECK;
            ST_CHECK: state_n = ST_RESP;
            ST_RESP:  if (rsp_ready) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tgt_r     <= '0;
            j         <= '0;
            k         <= '0;
            rsp_valid <= 1'b0;
            rsp_match <= 1'b0;
            rsp_q     <= '0;
            err_cnt   <= '0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (tgt_valid) begin
                        tgt_r <= tgt_data;
                        j     <= j_n;
                        k     <= k_n;
                    end
                end
                // The bank samples the excitation at this edge; drop back to hold.
                ST_DRIVE: begin
                    j <= '0;
                    k <= '0;
                end
                ST_CHECK: begin
                    rsp_q     <= q_fb;
                    rsp_match <= (q_fb == tgt_r);
                    rsp_valid <= 1'b1;
                    if ((q_fb != tgt_r) && (err_cnt != ERR_MAX))
                        err_cnt <= err_cnt + 1'b1;
                end
                ST_RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
